// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding definitions: opcode values, field widths, encoder FSM states
// and the supported-opcode predicate used by the legality check.
package mips_pkg;

  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int WORD_W   = 32;

  localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000000;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'b000001;
  localparam logic [OP_W-1:0] OP_J      = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL    = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE    = 6'b000101;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'b000110;
  localparam logic [OP_W-1:0] OP_ADDIU  = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'b001010;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'b001011;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI    = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI   = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI    = 6'b001111;
  localparam logic [OP_W-1:0] OP_LB     = 6'b100000;
  localparam logic [OP_W-1:0] OP_LW     = 6'b100011;
  localparam logic [OP_W-1:0] OP_SB     = 6'b101000;
  localparam logic [OP_W-1:0] OP_SW     = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } enc_state_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ,
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LW, OP_SB, OP_SW: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-field stream into the encoder: valid/ready handshake, last marker and
// the raw MIPS fields. master = field source, slave = encoder.
interface instr_encoder_if;
  import mips_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [OP_W-1:0]     in_op;
  logic [REG_W-1:0]    in_rs;
  logic [REG_W-1:0]    in_rt;
  logic [REG_W-1:0]    in_rd;
  logic [REG_W-1:0]    in_shamt;
  logic [FUNCT_W-1:0]  in_funct;
  logic [IMM_W-1:0]    in_imm;
  logic [TARGET_W-1:0] in_target;

  modport master (
    output in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, in_op, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target,
    output in_ready
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational R/I/J field packer plus opcode legality flag.
// Define INSTR_ENC_OPCHECK_EN to enable the legality check; otherwise every op is legal.
module instr_pack
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]     op,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    shamt,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TARGET_W-1:0] target,
  output logic [WORD_W-1:0]   word,
  output logic                legal
);

  always_comb begin
    word = {op, rs, rt, imm};
    case (op)
      OP_RTYPE:    word = {op, rs, rt, rd, shamt, funct};
      OP_J, OP_JAL: word = {op, target};
      // REGIMM carries its sub-opcode in rt, which the source does not supply.
      OP_REGIMM:   word = {op, rs, {REG_W{1'b0}}, imm};
      OP_LUI:      word = {op, {REG_W{1'b0}}, rt, imm};
      default:     ;
    endcase
  end

`ifdef INSTR_ENC_OPCHECK_EN
  assign legal = op_is_legal(op);
`else
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / imem loader: FSM, address and count registers, registered
// write port. Legality checking is compiled in with INSTR_ENC_OPCHECK_EN.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  localparam int               CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  instr_encoder_if.slave     in_bus,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [WORD_W-1:0]  imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               err_overflow,
  output logic [CNT_W-1:0]   word_count
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

  enc_state_t          state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                imem_we_reg;
  logic [ADDR_W-1:0]   imem_addr_reg;
  logic [WORD_W-1:0]   imem_wdata_reg;
  logic                done_reg;
  logic                err_illegal_reg;
  logic                err_overflow_reg;

  logic [WORD_W-1:0]   pack_word;
  logic                pack_legal;
  logic                accept;
  logic [CNT_W-1:0]    count_next;

  instr_pack u_pack (
    .op     (in_bus.in_op),
    .rs     (in_bus.in_rs),
    .rt     (in_bus.in_rt),
    .rd     (in_bus.in_rd),
    .shamt  (in_bus.in_shamt),
    .funct  (in_bus.in_funct),
    .imm    (in_bus.in_imm),
    .target (in_bus.in_target),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign in_bus.in_ready = (state_reg == ST_RUN) && (count_reg < DEPTH_CNT);
  assign accept          = in_bus.in_valid && in_bus.in_ready;
  assign count_next      = count_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= BASE_ADDR;
      count_reg        <= '0;
      imem_we_reg      <= 1'b0;
      imem_addr_reg    <= BASE_ADDR;
      imem_wdata_reg   <= '0;
      done_reg         <= 1'b0;
      err_illegal_reg  <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      imem_we_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg        <= ST_RUN;
            addr_reg         <= BASE_ADDR;
            count_reg        <= '0;
            err_illegal_reg  <= 1'b0;
            err_overflow_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (pack_legal) begin
              imem_we_reg    <= 1'b1;
              imem_addr_reg  <= addr_reg;
              imem_wdata_reg <= pack_word;
              addr_reg       <= addr_reg + ADDR_W'(4);
              count_reg      <= count_next;
            end else begin
              err_illegal_reg <= 1'b1;
            end
            // A last-marked word closes the load cleanly even if it fills the memory.
            if (in_bus.in_last) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else if (pack_legal && count_next == DEPTH_CNT) begin
              state_reg        <= ST_DONE;
              done_reg         <= 1'b1;
              err_overflow_reg <= 1'b1;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign imem_we      = imem_we_reg;
  assign imem_addr    = imem_addr_reg;
  assign imem_wdata   = imem_wdata_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign done         = done_reg;
  assign err_illegal  = err_illegal_reg;
  assign err_overflow = err_overflow_reg;
  assign word_count   = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: hand latency sequences, a packing vector
// table, reset/overflow corner cases and randomized loads against a reference model.
module tb_instr_encoder;
  import mips_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE = 32'h0;
`ifdef INSTR_ENC_OPCHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } fields_t;

  typedef struct {
    fields_t     f;
    logic [31:0] word;
    bit          legal;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic            imem_we;
  logic [31:0]     imem_addr;
  logic [31:0]     imem_wdata;
  logic            busy, done, err_illegal, err_overflow;
  logic [CW-1:0]   word_count;

  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_bus       (bus),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .busy         (busy),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow),
    .word_count   (word_count)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  fields_t items[16];
  vec_t    vecs[10];
  int legal_ops[18] = '{0, 1, 2, 3, 4, 5, 6, 9, 10, 11, 12, 13, 14, 15, 32, 35, 40, 43};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic fields_t mk(input int op, input int rs, input int rt, input int rd,
                                 input int shamt, input int funct, input int imm,
                                 input int target, input bit last);
    fields_t f;
    f.op = 6'(op); f.rs = 5'(rs); f.rt = 5'(rt); f.rd = 5'(rd); f.shamt = 5'(shamt);
    f.funct = 6'(funct); f.imm = 16'(imm); f.target = 26'(target); f.last = last;
    return f;
  endfunction

  function automatic bit legal_ref(input logic [5:0] op);
    foreach (legal_ops[i]) if (int'(op) == legal_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Field placement by bit position: op at 26, rs at 21, rt at 16, rd at 11, shamt at 6.
  function automatic logic [31:0] pack_ref(input fields_t f);
    int unsigned op = f.op;
    int unsigned w;
    if (op == 0)
      w = (op << 26) + (32'(f.rs) << 21) + (32'(f.rt) << 16) + (32'(f.rd) << 11)
        + (32'(f.shamt) << 6) + 32'(f.funct);
    else if (op == 2 || op == 3)
      w = (op << 26) + 32'(f.target);
    else
      w = (op << 26) + ((op == 15) ? 0 : (32'(f.rs) << 21))
        + ((op == 1) ? 0 : (32'(f.rt) << 16)) + 32'(f.imm);
    return w;
  endfunction

  function automatic fields_t rand_fields(input bit legal_only);
    fields_t f;
    f = mk($urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
           $urandom_range(0, 65535), $urandom, 1'b0);
    if (legal_only || $urandom_range(0, 9) < 7) f.op = 6'(legal_ops[$urandom_range(0, 17)]);
    return f;
  endfunction

  task automatic drive_fields(input fields_t f);
    bus.in_op = f.op; bus.in_rs = f.rs; bus.in_rt = f.rt; bus.in_rd = f.rd;
    bus.in_shamt = f.shamt; bus.in_funct = f.funct; bus.in_imm = f.imm;
    bus.in_target = f.target; bus.in_last = f.last;
  endtask

  task automatic clear_capture();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_items(input int n, input int bub_pct, output int n_acc);
    bit got;
    n_acc = 0;
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(0, 99)) < bub_pct) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      drive_fields(items[i]);
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 12 && !got; w++) begin
        @(negedge clk);
        if (bus.in_ready) got = 1'b1;
        @(posedge clk); #1;
      end
      if (!got) break;
      n_acc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 40; w++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Walk the input list in order, deciding acceptance, writes and end-of-load.
  task automatic model(input int n, output int acc, output bit ovf, output bit ill, output int k);
    acc = 0; ovf = 1'b0; ill = 1'b0; k = 0;
    exp_addr_q.delete(); exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      acc++;
      if (!CHK || legal_ref(items[i].op)) begin
        exp_addr_q.push_back(BASE + 32'(4 * k));
        exp_data_q.push_back(pack_ref(items[i]));
        k++;
      end else begin
        ill = 1'b1;
      end
      if (items[i].last) break;
      if (k == DEPTH) begin ovf = 1'b1; break; end
    end
  endtask

  task automatic run_load(input string tag, input int n, input int bub_pct);
    int n_acc, e_acc, e_k;
    bit e_ovf, e_ill;
    clear_capture();
    start_pulse();
    send_items(n, bub_pct, n_acc);
    wait_idle();
    model(n, e_acc, e_ovf, e_ill, e_k);
    check({tag, "_accepted"}, 64'(n_acc), 64'(e_acc));
    check({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size(); i++) begin
      check({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(exp_addr_q[i]));
      check({tag, "_wdata"}, 64'(wr_data_q[i]), 64'(exp_data_q[i]));
    end
    check({tag, "_err_ovf"}, 64'(err_overflow), 64'(e_ovf));
    check({tag, "_err_ill"}, 64'(err_illegal), 64'(e_ill));
    check({tag, "_word_count"}, 64'(word_count), 64'(e_k));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    $display("load %s: sent %0d accepted %0d writes %0d ovf %0d ill %0d",
             tag, n, n_acc, wr_addr_q.size(), err_overflow, err_illegal);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    drive_fields(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0));

    vecs[0] = '{mk(9, 0, 8, 17, 3, 12, 5, 0, 1'b1),            32'h24080005, 1'b1};
    vecs[1] = '{mk(0, 1, 2, 3, 0, 32, 16'hBEEF, 5, 1'b1),      32'h00221820, 1'b1};
    vecs[2] = '{mk(2, 7, 7, 7, 7, 7, 7, 26'h10, 1'b1),         32'h08000010, 1'b1};
    vecs[3] = '{mk(35, 29, 9, 0, 0, 0, 4, 26'h3, 1'b1),        32'h8FA90004, 1'b1};
    vecs[4] = '{mk(1, 3, 7, 9, 1, 1, 16'hFFFF, 0, 1'b1),       32'h0460FFFF, 1'b1};
    vecs[5] = '{mk(15, 5, 4, 0, 0, 0, 16'h1234, 0, 1'b1),      32'h3C041234, 1'b1};
    vecs[6] = '{mk(3, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF, 1'b1),    32'h0FFFFFFF, 1'b1};
    vecs[7] = '{mk(43, 31, 31, 0, 0, 0, 16'h8000, 0, 1'b1),    32'hAFFF8000, 1'b1};
    vecs[8] = '{mk(63, 1, 2, 0, 0, 0, 3, 0, 1'b1),             32'hFC220003, 1'b0};
    vecs[9] = '{mk(0, 0, 5, 6, 31, 0, 16'h1111, 0, 1'b1),      32'h000537C0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({imem_we, busy, done, err_illegal, err_overflow, bus.in_ready}), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'(BASE));
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single addiu: write one cycle after accept, done alongside, busy falls after.
    clear_capture();
    start_pulse();
    check("t1_busy_after_start", 64'(busy), 64'd1);
    check("t1_ready_after_start", 64'(bus.in_ready), 64'd1);
    drive_fields(vecs[0].f);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("t1_we", 64'(imem_we), 64'd1);
    check("t1_addr", 64'(imem_addr), 64'h0);
    check("t1_wdata", 64'(imem_wdata), 64'h24080005);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_word_count", 64'(word_count), 64'd1);
    @(posedge clk); #1;
    check("t1_after", 64'({imem_we, done, busy}), 64'd0);
    $display("load t1: addiu single word, writes %0d", wr_addr_q.size());

    for (int i = 0; i < 10; i++) begin
      items[0] = vecs[i].f;
      run_load($sformatf("tbl%0d", i), 1, 0);
      if (vecs[i].legal || !CHK) check($sformatf("tbl%0d_const_word", i), 64'(wr_data_q[0]), 64'(vecs[i].word));
    end

    items[0] = mk(0, 1, 2, 3, 0, 32, 0, 0, 1'b0);
    items[1] = mk(2, 0, 0, 0, 0, 0, 0, 26'h10, 1'b0);
    items[2] = mk(35, 29, 9, 0, 0, 0, 4, 0, 1'b1);
    run_load("stream3", 3, 0);
    check("stream3_w0", 64'(wr_data_q[0]), 64'h00221820);
    check("stream3_w2", 64'(wr_data_q[2]), 64'h8FA90004);
    check("stream3_consecutive", 64'(wr_cyc_q[2] - wr_cyc_q[0]), 64'd2);

    items[0] = mk(9, 0, 8, 0, 0, 0, 5, 0, 1'b0);
    items[1] = mk(63, 1, 2, 0, 0, 0, 3, 0, 1'b0);
    items[2] = mk(35, 29, 9, 0, 0, 0, 4, 0, 1'b1);
    run_load("illegal_mid", 3, 0);
    check("illegal_mid_count", 64'(wr_addr_q.size()), CHK ? 64'd2 : 64'd3);
    check("illegal_mid_addr1", 64'(wr_addr_q[1]), 64'h4);

    for (int i = 0; i < DEPTH + 1; i++) items[i] = rand_fields(1'b1);
    run_load("overflow", DEPTH + 1, 0);
    check("overflow_flag", 64'(err_overflow), 64'd1);
    check("overflow_last_addr", 64'(wr_addr_q[DEPTH-1]), 64'(BASE + 32'(4 * (DEPTH - 1))));

    // Reset two words into a load; the word accepted on the reset edge must not appear.
    clear_capture();
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      drive_fields(rand_fields(1'b1));
      bus.in_valid = 1'b1;
      if (i == 2) reset = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    check("rst_mid_ctrl", 64'({imem_we, busy, done, err_illegal, err_overflow, bus.in_ready}), 64'd0);
    check("rst_mid_count", 64'(word_count), 64'd0);
    check("rst_mid_addr", 64'(imem_addr), 64'(BASE));
    repeat (4) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    check("rst_mid_writes", 64'(wr_addr_q.size()), 64'd2);
    items[0] = mk(9, 0, 8, 0, 0, 0, 5, 0, 1'b1);
    run_load("after_rst", 1, 0);

    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("start_with_reset", 64'({busy, bus.in_ready}), 64'd0);

    for (int i = 0; i < 6; i++) items[i] = rand_fields(1'b1);
    items[5].last = 1'b1;
    run_load("bubbles6", 6, 50);

    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        n = DEPTH + 2;
        for (int i = 0; i < n; i++) items[i] = rand_fields(1'b1);
      end else begin
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) items[i] = rand_fields(1'b0);
        items[n-1].last = 1'b1;
      end
      run_load($sformatf("rand%0d", r), n, $urandom_range(0, 60));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
